// File: rtl/pipe_src_arbiter.sv
// pipe_src_arbiter: round-robin merge of N_SRC one-deep source holding registers onto one FIFO write port (tag words optional via PIPE_ARB_TAG_EN).
// Latency: strobe -> wr_en_out after 2 edges (3 with tag word); one data word per 2 cycles (3 with tag).
// Backpressure: fifo_full_in stalls grant and write with the granted word held; re-strobed pending sources are overwritten and counted as drops.
module pipe_src_arbiter #(
    parameter int N_SRC  = 8,
    parameter int W_DATA = 16,
    parameter int W_DROP = 16
) (
    input  logic                    clk50_in,
    input  logic                    reset_in,
    input  logic [N_SRC-1:0]        src_en_in,
    input  logic [N_SRC-1:0]        data_valid_in,
    input  logic [N_SRC*W_DATA-1:0] data_in,
    input  logic                    fifo_full_in,
    output logic                    wr_en_out,
    output logic [W_DATA-1:0]       wr_data_out,
    output logic [7:0]              grant_idx_out,
    output logic                    busy_out,
    output logic [W_DROP-1:0]       drop_count_out
);
    localparam int W_IDX = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int W_SUM = W_DROP + 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              state;
    logic [N_SRC-1:0]    pend;
    logic [W_DATA-1:0]   hold [N_SRC];
    logic [W_IDX-1:0]    last;
    logic [W_IDX-1:0]    g_idx;
    logic [W_DATA-1:0]   gdata;

    logic [N_SRC-1:0]    elig;
    logic [2*N_SRC-1:0]  elig_dbl;
    logic [N_SRC-1:0]    elig_rot;
    logic                win_vld;
    int                  win_off;
    logic [W_IDX-1:0]    win_idx;
    logic                grant_now;
    logic [N_SRC-1:0]    gnt_mask;
    logic [N_SRC-1:0]    ovr;
    logic [W_SUM-1:0]    ovr_cnt;
    logic [W_SUM-1:0]    drop_sum;
    logic [W_DROP-1:0]   drop_next;

    // Rotate eligibility so bit 0 is the source just after the last one served.
    always_comb begin
        elig     = pend & src_en_in;
        elig_dbl = {elig, elig} >> (int'(last) + 1);
        elig_rot = elig_dbl[N_SRC-1:0];
        win_vld  = 1'b0;
        win_off  = 0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (elig_rot[j]) begin
                win_vld = 1'b1;
                win_off = j;
            end
        end
        win_idx   = W_IDX'((int'(last) + 1 + win_off) % N_SRC);
        grant_now = (state == S_IDLE) && win_vld && !fifo_full_in;
        gnt_mask  = grant_now ? (N_SRC'(1) << win_idx) : '0;
    end

    // A strobe on the source being granted this cycle refills it rather than overrunning.
    always_comb begin
        ovr     = data_valid_in & src_en_in & pend & ~gnt_mask;
        ovr_cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ovr_cnt = ovr_cnt + W_SUM'(ovr[i]);
        end
        drop_sum  = W_SUM'(drop_count_out) + ovr_cnt;
        drop_next = (|drop_sum[W_SUM-1:W_DROP]) ? '1 : drop_sum[W_DROP-1:0];
    end

    assign busy_out = (state != S_IDLE) || (|pend);

    always_ff @(posedge clk50_in) begin
        if (reset_in) begin
            state          <= S_IDLE;
            pend           <= '0;
            last           <= W_IDX'(N_SRC - 1);
            g_idx          <= '0;
            gdata          <= '0;
            wr_en_out      <= 1'b0;
            wr_data_out    <= '0;
            grant_idx_out  <= '0;
            drop_count_out <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                hold[i] <= '0;
            end
        end else begin
            wr_en_out      <= 1'b0;
            drop_count_out <= drop_next;

            for (int i = 0; i < N_SRC; i++) begin
                if (!src_en_in[i]) begin
                    pend[i] <= 1'b0;
                end else if (data_valid_in[i]) begin
                    hold[i] <= data_in[i*W_DATA +: W_DATA];
                    pend[i] <= 1'b1;
                end else if (gnt_mask[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        g_idx <= win_idx;
                        gdata <= hold[win_idx];
`ifdef PIPE_ARB_TAG_EN
                        state <= S_TAG;
`else
                        state <= S_DATA;
`endif
                    end
                end
`ifdef PIPE_ARB_TAG_EN
                S_TAG: begin
                    if (!fifo_full_in) begin
                        wr_en_out   <= 1'b1;
                        wr_data_out <= W_DATA'({8'hA5, 8'(g_idx)});
                        state       <= S_DATA;
                    end
                end
`endif
                S_DATA: begin
                    if (!fifo_full_in) begin
                        wr_en_out     <= 1'b1;
                        wr_data_out   <= gdata;
                        grant_idx_out <= 8'(g_idx);
                        last          <= g_idx;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
